jpeg_bitstream_writer: RTL and testbench
========================================

# jpeg_bitstream_writer

Entropy-coded-segment bit packer for the JPEG encoder path; it is the transmit-side counterpart of the decoder's bitstream reader. It accepts variable-length codewords (Huffman code plus appended amplitude bits) from the entropy encoder and packs them MSB-first into bytes. It inserts 0x00 after every 0xFF data byte and pads the final partial byte with 1s on flush. Bytes leave on a valid/ready stream toward the output byte sink.

## Interface
- ACC_W, 64: bit accumulator width; fixed at 64, not user-tunable.
- clk  in  1  clock.
- rst_n  in  1  reset, asynchronous, active-low.
- code_in  in  32  codeword; only the low code_len bits are used, and bit [code_len-1] is sent first.
- code_len  in  6  number of valid bits, 0..32; values above 32 are clamped to 32.
- code_valid  in  1  codeword offered.
- code_ready  out  1  codeword accepted on the cycle where code_valid && code_ready.
- flush  in  1  end-of-scan request, sampled only when code_ready=1.
- byte_out  out  8  output byte.
- byte_valid  out  1  byte_out holds a valid byte.
- byte_ready  in  1  sink accepts byte_out on the cycle where byte_valid && byte_ready.
- flush_done  out  1  one-cycle pulse after the last flush byte is accepted.
- idle  out  1  no bits pending, no byte held, state RUN.

## Operation
- Accumulator acc[63:0] is left-aligned, with bit_cnt (0..64) counting valid bits from the MSB.
- Accept a codeword: append code bits below the existing bits, bit_cnt += code_len. code_len=0 is accepted and has no effect.
- code_ready = (state==RUN) && (bit_cnt <= 32) && !flush_pend. The accumulator therefore cannot overflow.
- Output register loads when it is empty or being drained (!byte_valid || byte_ready). Load priority, highest first:
  - STUFF state: load 0x00.
  - RUN or FLUSH with bit_cnt >= 8: load acc[63:56], shift the accumulator left by 8, bit_cnt -= 8.
  - EOI states: load the marker byte.
- A data byte equal to 0xFF moves the FSM to STUFF. The 0x00 is loaded on the next load opportunity after the FF is loaded. No other byte may come between the FF and its 0x00.
- Flush: if flush=1 while code_ready=1, set flush_pend. If code_valid is also high that cycle, the codeword is appended first, then flushed.
- FSM states: RUN, STUFF, FLUSH, EOI_FF, EOI_D9, DONE.
  - RUN → FLUSH when flush_pend is set.
  - FLUSH: drain all whole bytes. If 0 < bit_cnt < 8, fill the remaining bits with 1s and emit that byte.
  - A padded byte that becomes 0xFF is stuffed like any data byte.
  - Once bit_cnt=0 and no byte remains to emit: go to EOI_FF when JPEG_BSW_EOI_EN is defined, else DONE.
  - EOI_FF, EOI_D9: emit 0xFF then 0xD9. The marker 0xFF is not stuffed.
  - DONE: wait for the last byte to be accepted, pulse flush_done, clear flush_pend, return to RUN with the accumulator empty.
  - STUFF returns to the state it was entered from.
- Reset mid-operation: all state cleared immediately; pending bits and the held byte are discarded.

## Timing
- Reset values: byte_out=0x00, byte_valid=0, flush_done=0, state=RUN, bit_cnt=0. code_ready=1 and idle=1 combinationally once reset state is reached.
- Latency: a codeword accepted at cycle N that completes a byte gives byte_valid=1 at N+1.
- Throughput: 1 byte per cycle, including stuff bytes; codewords are accepted 1 per cycle while bit_cnt <= 32.
- Backpressure: while byte_valid && !byte_ready, byte_out and byte_valid hold stable. Codewords continue to be accepted until bit_cnt > 32.
- Accepting a codeword and loading a byte in the same cycle is allowed. The update is bit_cnt' = bit_cnt + len - 8, and the codeword is placed relative to the post-shift accumulator.
- flush_done asserts the cycle after the final byte handshake. code_ready stays 0 from flush acceptance until the cycle after flush_done.

## Configuration
- JPEG_BSW_EOI_EN defined: the flush sequence appends the EOI marker FF D9 after the padded data.
- Not defined: the flush ends at the padded data byte; EOI_FF and EOI_D9 are unreachable. The header/marker writer emits EOI.

## Test plan
- Codes 0xA (len 4), then 0xB (len 4), byte_ready=1 → single byte 0xAB one cycle after the second accept; idle returns to 1.
- Code 0xFF (len 8) → bytes 0xFF, 0x00 on consecutive cycles.
- Code 0b101 (len 3) plus flush → 0xBF. With EOI_EN: 0xBF, 0xFF, 0xD9, then flush_done pulse. Code 0b1 (len 1) plus flush → 0xFF, 0x00, then the EOI bytes if enabled.
- Codes 0x12345678 (len 32), then 0xFFFFFFFF (len 32), byte_ready=1 → bytes 12 34 56 78 FF 00 FF 00 FF 00 FF 00. code_ready drops after the second accept (bit_cnt > 32) and returns to 1 once bit_cnt <= 32.
- byte_ready held low for 5 cycles with 0xAB pending → byte_out stays 0xAB with valid=1. Codes of len 16 are accepted until bit_cnt > 32, then code_ready=0. After release, bytes drain in order.
- Assert rst_n low mid-flush with bits pending → byte_valid=0 and flush_done=0 immediately. After release, a fresh code 0xAB (len 8) yields 0xAB with no stale bits.

Source files
------------

// File: rtl/jpeg_bitstream_writer.sv
// MSB-first entropy-coded-segment packer with 0xFF/0x00 byte stuffing and 1-padding on flush.
// Define JPEG_BSW_EOI_EN to append the FF D9 EOI marker at the end of each flush.
module jpeg_bitstream_writer (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [31:0] code_in,
  input  logic [5:0]  code_len,
  input  logic        code_valid,
  output logic        code_ready,
  input  logic        flush,
  output logic [7:0]  byte_out,
  output logic        byte_valid,
  input  logic        byte_ready,
  output logic        flush_done,
  output logic        idle,
  output logic [2:0]  state_dbg
);

  localparam int ACC_W = 64;

  // Handshakes: a codeword moves on the rising edge where code_valid && code_ready;
  // a byte moves on the rising edge where byte_valid && byte_ready.
  typedef enum logic [2:0] {
    S_RUN    = 3'd0,
    S_STUFF  = 3'd1,
    S_FLUSH  = 3'd2,
    S_EOI_FF = 3'd3,
    S_EOI_D9 = 3'd4,
    S_DONE   = 3'd5
  } state_t;

  state_t state, state_nxt, ret_state, ret_nxt;

  logic [ACC_W-1:0] acc, ins, merged;
  logic [6:0]       bit_cnt, merged_cnt, ins_sh;
  logic [5:0]       len_c;
  logic [31:0]      code_mask;
  logic             flush_pend, flush_go;
  logic             accept, out_free;
  logic             data_ld, pad_ld, stuff_ld, eoi_ld, load, done_set;
  logic [7:0]       load_byte;

  assign len_c      = (code_len > 6'd32) ? 6'd32 : code_len;
  assign code_ready = (state == S_RUN) && (bit_cnt <= 7'd32) && !flush_pend;
  assign accept     = code_valid && code_ready;
  assign out_free   = !byte_valid || byte_ready;
  // flush_pend stays set through the flush_done cycle so code_ready reopens one cycle later
  assign flush_go   = flush_pend && !flush_done;

  // The new codeword is merged below the existing bits before any byte is taken,
  // so a codeword that completes a byte is visible on byte_out the next cycle.
  assign code_mask  = code_in & ~(32'hFFFF_FFFF << len_c);
  assign ins_sh     = 7'd64 - {1'b0, len_c} - bit_cnt;
  assign ins        = accept ? ({32'd0, code_mask} << ins_sh) : {ACC_W{1'b0}};
  assign merged     = acc | ins;
  assign merged_cnt = bit_cnt + (accept ? {1'b0, len_c} : 7'd0);

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= S_RUN;
      ret_state <= S_RUN;
    end else begin
      state     <= state_nxt;
      ret_state <= ret_nxt;
    end
  end

  // Next-state logic
  always_comb begin
    state_nxt = state;
    ret_nxt   = ret_state;
    case (state)
      S_RUN: begin
        if (data_ld && load_byte == 8'hFF) begin
          state_nxt = S_STUFF;
          ret_nxt   = flush_go ? S_FLUSH : S_RUN;
        end else if (flush_go) begin
          state_nxt = S_FLUSH;
        end
      end
      S_STUFF: begin
        if (stuff_ld) state_nxt = ret_state;
      end
      S_FLUSH: begin
        if ((data_ld || pad_ld) && load_byte == 8'hFF) begin
          state_nxt = S_STUFF;
          ret_nxt   = S_FLUSH;
        end else if (merged_cnt == 7'd0) begin
`ifdef JPEG_BSW_EOI_EN
          state_nxt = S_EOI_FF;
`else
          state_nxt = out_free ? S_RUN : S_DONE;
`endif
        end
      end
      S_EOI_FF: begin
        if (eoi_ld) state_nxt = S_EOI_D9;
      end
      S_EOI_D9: begin
        if (eoi_ld) state_nxt = S_DONE;
      end
      S_DONE: begin
        if (out_free) state_nxt = S_RUN;
      end
      default: state_nxt = S_RUN;
    endcase
  end

  // Output / load selection
  always_comb begin
    data_ld   = out_free && (state == S_RUN || state == S_FLUSH) && (merged_cnt >= 7'd8);
    pad_ld    = out_free && (state == S_FLUSH) && (merged_cnt != 7'd0) && (merged_cnt < 7'd8);
    stuff_ld  = out_free && (state == S_STUFF);
    eoi_ld    = out_free && (state == S_EOI_FF || state == S_EOI_D9);
    load      = data_ld || pad_ld || stuff_ld || eoi_ld;
    load_byte = 8'h00;
    if (stuff_ld)       load_byte = 8'h00;
    else if (data_ld)   load_byte = merged[ACC_W-1 -: 8];
    else if (pad_ld)    load_byte = merged[ACC_W-1 -: 8] | (8'hFF >> merged_cnt[2:0]);
    else if (eoi_ld)    load_byte = (state == S_EOI_FF) ? 8'hFF : 8'hD9;
    done_set = (state == S_DONE) && out_free;
`ifndef JPEG_BSW_EOI_EN
    if (state == S_FLUSH && merged_cnt == 7'd0 && out_free) done_set = 1'b1;
`endif
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc        <= {ACC_W{1'b0}};
      bit_cnt    <= 7'd0;
      byte_out   <= 8'h00;
      byte_valid <= 1'b0;
      flush_pend <= 1'b0;
      flush_done <= 1'b0;
    end else begin
      if (data_ld) begin
        acc     <= merged << 8;
        bit_cnt <= merged_cnt - 7'd8;
      end else if (pad_ld || done_set) begin
        acc     <= {ACC_W{1'b0}};
        bit_cnt <= 7'd0;
      end else begin
        acc     <= merged;
        bit_cnt <= merged_cnt;
      end

      if (load) begin
        byte_out   <= load_byte;
        byte_valid <= 1'b1;
      end else if (byte_ready) begin
        byte_valid <= 1'b0;
      end

      if (flush && code_ready) flush_pend <= 1'b1;
      else if (flush_done)     flush_pend <= 1'b0;

      flush_done <= done_set;
    end
  end

  assign idle      = (bit_cnt == 7'd0) && !byte_valid && (state == S_RUN);
  assign state_dbg = state;

endmodule

// File: tb/tb_jpeg_bitstream_writer.sv
// Scoreboard bench for jpeg_bitstream_writer: a bit-queue reference model predicts the byte
// stream; a monitor pops and compares on every byte handshake.
module tb_jpeg_bitstream_writer;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [31:0] code_in = '0;
  logic [5:0]  code_len = '0;
  logic        code_valid = 1'b0;
  logic        code_ready;
  logic        flush = 1'b0;
  logic [7:0]  byte_out;
  logic        byte_valid;
  logic        byte_ready = 1'b1;
  logic        flush_done;
  logic        idle;
  logic [2:0]  state_dbg;

  always #5 clk = ~clk;

  jpeg_bitstream_writer dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .code_in    (code_in),
    .code_len   (code_len),
    .code_valid (code_valid),
    .code_ready (code_ready),
    .flush      (flush),
    .byte_out   (byte_out),
    .byte_valid (byte_valid),
    .byte_ready (byte_ready),
    .flush_done (flush_done),
    .idle       (idle),
    .state_dbg  (state_dbg)
  );

  logic [7:0] exp_q[$];
  bit         model_bits[$];
  int         checks = 0;
  int         errors = 0;
  int         exp_done = 0;
  int         got_done = 0;
  logic       bp_mode = 1'b0;
  logic       br_force = 1'b1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h t=%0t", name, act, exp, $time);
    end
  endtask

  // Reference model: a plain bit queue, bytes formed eight bits at a time
  function automatic void model_emit();
    logic [7:0] b;
    while (model_bits.size() >= 8) begin
      for (int i = 7; i >= 0; i--) b[i] = model_bits.pop_front();
      exp_q.push_back(b);
      if (b == 8'hFF) exp_q.push_back(8'h00);
    end
  endfunction

  function automatic void model_code(input logic [31:0] c, input logic [5:0] l);
    int n;
    n = (l > 6'd32) ? 32 : int'(l);
    for (int i = n - 1; i >= 0; i--) model_bits.push_back(c[i]);
    model_emit();
  endfunction

  function automatic void model_flush();
    while ((model_bits.size() % 8) != 0) model_bits.push_back(1'b1);
    model_emit();
`ifdef JPEG_BSW_EOI_EN
    exp_q.push_back(8'hFF);
    exp_q.push_back(8'hD9);
`endif
    exp_done++;
  endfunction

  always @(negedge clk) byte_ready = bp_mode ? ($urandom_range(0, 3) != 0) : br_force;

  // Monitor
  initial begin
    logic       prev_stall;
    logic [7:0] prev_byte;
    prev_stall = 1'b0;
    prev_byte  = 8'h00;
    forever begin
      @(negedge clk);
      #2;
      if (!rst_n) begin
        prev_stall = 1'b0;
      end else begin
        if (prev_stall) begin
          chk("hold_valid", {31'd0, byte_valid}, 32'd1);
          chk("hold_byte", {24'd0, byte_out}, {24'd0, prev_byte});
        end
        if (byte_valid && byte_ready) begin
          if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_byte actual=%h required=none t=%0t", byte_out, $time);
          end else begin
            chk("byte", {24'd0, byte_out}, {24'd0, exp_q.pop_front()});
          end
        end
        if (flush_done) begin
          got_done++;
          chk("done_q_empty", exp_q.size(), 32'd0);
          chk("ready_at_done", {31'd0, code_ready}, 32'd0);
        end
        prev_stall = byte_valid && !byte_ready;
        prev_byte  = byte_out;
      end
    end
  end

  // Offer a codeword and/or flush until accepted (bounded)
  task automatic drive(input logic [31:0] c, input logic [5:0] l, input logic v, input logic f);
    int  t;
    bit  ok;
    t  = 0;
    ok = 0;
    while (!ok && t < 300) begin
      @(negedge clk);
      code_in    = c;
      code_len   = l;
      code_valid = v;
      flush      = f;
      #1;
      if (code_ready) ok = 1;
      t++;
    end
    if (!ok) begin
      checks++;
      errors++;
      $display("FAIL send_timeout actual=code_ready_low required=accept t=%0t", $time);
    end else begin
      if (v) model_code(c, l);
      if (f) model_flush();
      @(posedge clk);
    end
    #1;
    code_valid = 1'b0;
    flush      = 1'b0;
  endtask

  task automatic wait_drain();
    int t;
    t = 0;
    while ((exp_q.size() != 0 || got_done != exp_done) && t < 3000) begin
      @(negedge clk);
      t++;
    end
    #3;
    chk("drain_q", exp_q.size(), 32'd0);
    chk("drain_done", got_done, exp_done);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int n_acc;
    int t;
    bit ok;
    logic [5:0] l;

    // Reset state
    repeat (3) @(negedge clk);
    #1;
    chk("rst_byte_valid", {31'd0, byte_valid}, 32'd0);
    chk("rst_byte_out", {24'd0, byte_out}, 32'd0);
    chk("rst_flush_done", {31'd0, flush_done}, 32'd0);
    chk("rst_code_ready", {31'd0, code_ready}, 32'd1);
    chk("rst_idle", {31'd0, idle}, 32'd1);
    chk("rst_state", {29'd0, state_dbg}, 32'd0);
    rst_n = 1'b1;

    // Two nibbles make one byte, visible one cycle after the second accept
    drive(32'hA, 6'd4, 1'b1, 1'b0);
    drive(32'hB, 6'd4, 1'b1, 1'b0);
    @(negedge clk);
    #1;
    chk("ab_valid", {31'd0, byte_valid}, 32'd1);
    chk("ab_byte", {24'd0, byte_out}, 32'hAB);
    @(negedge clk);
    #1;
    chk("ab_idle", {31'd0, idle}, 32'd1);

    // 0xFF is followed immediately by a stuffed 0x00
    drive(32'hFF, 6'd8, 1'b1, 1'b0);
    @(negedge clk);
    #1;
    chk("ff_byte", {24'd0, byte_out}, 32'hFF);
    @(negedge clk);
    #1;
    chk("stuff_valid", {31'd0, byte_valid}, 32'd1);
    chk("stuff_byte", {24'd0, byte_out}, 32'h00);
    wait_drain();

    // Flush with padding; padded 0xFF gets stuffed
    drive(32'h5, 6'd3, 1'b1, 1'b1);
    wait_drain();
    drive(32'h1, 6'd1, 1'b1, 1'b1);
    wait_drain();

    // Accumulator fill: code_ready drops after the second 32-bit accept
    drive(32'h1234_5678, 6'd32, 1'b1, 1'b0);
    drive(32'hFFFF_FFFF, 6'd32, 1'b1, 1'b0);
    @(negedge clk);
    #1;
    chk("full_ready_low", {31'd0, code_ready}, 32'd0);
    t  = 0;
    ok = 0;
    while (!ok && t < 20) begin
      @(negedge clk);
      #1;
      if (code_ready) ok = 1;
      t++;
    end
    chk("full_ready_back", {31'd0, code_ready}, 32'd1);
    wait_drain();

    // Backpressure: held byte stays stable, len-16 codes accepted until bit_cnt > 32
    br_force = 1'b0;
    repeat (2) @(negedge clk);
    drive(32'hAB, 6'd8, 1'b1, 1'b0);
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      #1;
      chk("bp_byte", {24'd0, byte_out}, 32'hAB);
      chk("bp_valid", {31'd0, byte_valid}, 32'd1);
    end
    n_acc = 0;
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      code_in    = $urandom;
      code_len   = 6'd16;
      code_valid = 1'b1;
      #1;
      if (!code_ready) break;
      model_code(code_in, 6'd16);
      n_acc++;
      @(posedge clk);
      #1;
      code_valid = 1'b0;
    end
    code_valid = 1'b0;
    chk("bp_accepts", n_acc, 32'd3);
    br_force = 1'b1;
    wait_drain();

    // Reset in the middle of a flush with bits pending and a byte held
    br_force = 1'b0;
    repeat (2) @(negedge clk);
    drive(32'h3C, 6'd6, 1'b1, 1'b0);
    drive(32'h155, 6'd9, 1'b1, 1'b0);
    drive(32'h2, 6'd2, 1'b1, 1'b1);
    repeat (2) @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("mid_rst_valid", {31'd0, byte_valid}, 32'd0);
    chk("mid_rst_done", {31'd0, flush_done}, 32'd0);
    exp_q.delete();
    model_bits.delete();
    exp_done = got_done;
    repeat (2) @(negedge clk);
    rst_n    = 1'b1;
    br_force = 1'b1;
    drive(32'hAB, 6'd8, 1'b1, 1'b0);
    @(negedge clk);
    #1;
    chk("post_rst_byte", {24'd0, byte_out}, 32'hAB);
    wait_drain();

    // Randomized traffic with random backpressure, lengths up to 40 (clamped)
    bp_mode = 1'b1;
    for (int i = 0; i < 300; i++) begin
      l = 6'($urandom_range(0, 40));
      if ($urandom_range(0, 99) < 5)
        drive($urandom, l, 1'($urandom_range(0, 1)), 1'b1);
      else
        drive($urandom, l, 1'b1, 1'b0);
      if ($urandom_range(0, 9) == 0) repeat ($urandom_range(1, 4)) @(negedge clk);
    end
    drive(32'h0, 6'd0, 1'b0, 1'b1);
    bp_mode = 1'b0;
    wait_drain();
    @(negedge clk);
    #1;
    chk("final_idle", {31'd0, idle}, 32'd1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
